// File: rtl/prio_arbiter_rr.sv
// Registered N-request arbiter with fixed-priority and round-robin modes.
// The winner is captured on the IDLE->GRANT edge and held until the consumer
// acks or the granted requester withdraws its request.
//
// Handshake: a grant is offered while valid = 1. It is retired on the first
// clock edge where ack = 1 or req[grant_idx] = 0. After a grant is retired there
// is always one IDLE cycle before the next grant. ack is ignored while valid = 0.
module prio_arbiter_rr #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    input  logic         rr_mode,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_oh,
    output logic         any_req,
    output logic         dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         any_req_q;

    logic [W-1:0] fx_win;
    logic [W-1:0] rr_win;
    logic [W-1:0] rr_cand;
    logic         rr_hit;

    // Fixed priority: the highest set index wins, so later loop hits override.
    always_comb begin
        fx_win = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) fx_win = W'(i);
        end
    end

    // Round-robin: scan ptr, ptr-1, ..., 0, N-1, ..., ptr+1; the first hit wins.
    always_comb begin
        rr_cand = ptr_q;
        rr_win  = ptr_q;
        rr_hit  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!rr_hit && req[rr_cand]) begin
                rr_hit = 1'b1;
                rr_win = rr_cand;
            end
            rr_cand = (rr_cand == '0) ? W'(N - 1) : rr_cand - 1'b1;
        end
    end

    // Next-state logic: capture the winner on entry, retire on ack or withdrawal.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (en && (|req)) begin
                    state_d = GRANT;
                    idx_d   = rr_mode ? rr_win : fx_win;
                end
            end
            GRANT: begin
                if (ack || !req[idx_q]) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    ptr_d   = (idx_q == '0) ? W'(N - 1) : idx_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, held index, rotation pointer and the registered any-request flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ptr_q     <= W'(N - 1);
            any_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            any_req_q <= |req;
        end
    end

    assign valid     = (state_q == GRANT);
    assign grant_idx = idx_q;
    assign grant_oh  = valid ? (N'(1) << idx_q) : '0;
    assign any_req   = any_req_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Directed bench for prio_arbiter_rr with N = 8.
module tb_prio_arbiter_rr;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         en;
  logic         rr_mode;
  logic         ack;
  logic         valid;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_oh;
  logic         any_req;
  logic         dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [W-1:0] exp_q[$];

  prio_arbiter_rr #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .en        (en),
    .rr_mode   (rr_mode),
    .ack       (ack),
    .valid     (valid),
    .grant_idx (grant_idx),
    .grant_oh  (grant_oh),
    .any_req   (any_req),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge; inputs changed afterwards apply at the next edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [W-1:0] idx);
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    check_eq({tag, "_valid"}, 32'(valid), 32'd1);
    check_eq({tag, "_idx"}, 32'(grant_idx), 32'(idx));
    check_eq({tag, "_oh"}, 32'(grant_oh), 32'(oh));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, 32'(valid), 32'd0);
    check_eq({tag, "_idx"}, 32'(grant_idx), 32'd0);
    check_eq({tag, "_oh"}, 32'(grant_oh), 32'd0);
  endtask

  // ack the held grant; the arbiter must be idle after that edge
  task automatic do_ack(input string tag);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check_idle({tag, "_acked"});
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    en      = 1'b0;
    rr_mode = 1'b0;
    ack     = 1'b0;
    repeat (2) step();
    check_idle("rst");
    check_eq("rst_any", 32'(any_req), 32'd0);
    rst_n = 1'b1;
    step();

    // fixed-priority encoding
    en = 1'b1;
    req = 8'h01;
    step();
    check_grant("fx01", 3'd0);
    check_eq("fx01_any", 32'(any_req), 32'd1);
    do_ack("fx01");
    req = 8'h0A;
    step();
    check_grant("fx0A", 3'd3);
    do_ack("fx0A");
    req = 8'hFF;
    step();
    check_grant("fxFF", 3'd7);
    do_ack("fxFF");

    // ack while idle is ignored; any_req tracks the inputs
    req = 8'h00;
    ack = 1'b1;
    step();
    ack = 1'b0;
    check_idle("idle_ack");
    check_eq("idle_any", 32'(any_req), 32'd0);

    // hold until ack, then one idle cycle, then the next winner
    req = 8'h10;
    step();
    check_grant("hold_a", 3'd4);
    req = 8'h90;
    step();
    check_grant("hold_b", 3'd4);
    do_ack("hold");
    step();
    check_grant("hold_next", 3'd7);
    do_ack("hold_next");

    // withdrawal retires the grant without ack (ptr becomes 1)
    req = 8'h04;
    step();
    check_grant("wd", 3'd2);
    req = 8'h00;
    step();
    check_idle("wd_drop");

    // disable blocks new grants
    en  = 1'b0;
    req = 8'hFF;
    step();
    check_idle("dis_a");
    step();
    check_idle("dis_b");

    // en = 0 during GRANT keeps the grant; mode change while holding has no effect
    en = 1'b1;
    step();
    check_grant("ms_fx", 3'd7);
    rr_mode = 1'b1;
    en = 1'b0;
    step();
    check_grant("ms_hold", 3'd7);
    en = 1'b1;
    do_ack("ms");
    // ptr = 6 now; rr mode applies on this entry
    step();
    check_grant("ms_rr", 3'd6);
    do_ack("ms_rr");
    // ptr = 5: search 5,4,...,0 finds bit 0 before bit 6
    req = 8'h41;
    step();
    check_grant("rr_sparse", 3'd0);
    do_ack("rr_sparse");

    // reset mid-grant clears outputs immediately and restores ptr = 7
    req = 8'h41;
    step();
    check_grant("pre_rst", 3'd6);
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
    step();
    rst_n = 1'b1;
    req = 8'hFF;
    step();

    // round-robin fairness with all requests held; first grant after reset is 7
    for (int i = 7; i >= 0; i--) exp_q.push_back(W'(i));
    exp_q.push_back(3'd7);
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check_grant("rr_seq", e);
      do_ack("rr_seq");
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
